// File: rtl/uart_tx_frame_engine_pkg.sv
// uart_pkg: shared definitions for the UART transmit frame engine.
//   uart_state_t          - frame FSM states (PARITY used only with UART_TX_PARITY_EN)
//   CLKS_PER_BIT_DEFAULT  - 50 MHz / 115200 baud
//   DATA_BITS, DISP_BITS  - payload width and display-decoder width
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam int CLKS_PER_BIT_DEFAULT = 434;
    localparam int DATA_BITS            = 8;
    localparam int DISP_BITS            = 7;

endpackage

// File: rtl/uart_tx_frame_engine_if.sv
// Byte handshake between a producer and the UART transmit frame engine.
//   tx_valid - byte offered on tx_data (producer -> engine)
//   tx_data  - byte to transmit        (producer -> engine)
//   tx_ready - engine can accept       (engine -> producer)
// modport master: producer side; modport slave: engine side.
interface uart_tx_frame_engine_if;
    import uart_pkg::*;

    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;

    modport master (output tx_valid, output tx_data, input  tx_ready);
    modport slave  (input  tx_valid, input  tx_data, output tx_ready);

endinterface

// File: rtl/uart_tx_frame_engine_baud_timer.sv
// uart_baud_timer: bit-period counter for the UART transmitter.
//   clock, reset - system clock, asynchronous active-high reset
//   clear        - hold the count at 0 (asserted while the engine is idle)
//   enable       - advance the count
//   bit_end      - high during the last clock (count CLKS_PER_BIT-1) of a bit
// The count wraps to 0 on bit_end, so each state that follows a bit boundary
// starts with a fresh count and no drift accumulates across the frame.
module uart_baud_timer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic bit_end
);

    localparam int            CW   = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_q;

    assign bit_end = enable && !clear && (count_q == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (enable) begin
            count_q <= bit_end ? '0 : count_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_frame_engine.sv
// uart_tx_frame_engine: serialises accepted bytes as 8N1 frames, LSB first.
// Optional macro UART_TX_PARITY_EN adds an even-parity bit (8E1, 11-bit frame).
//   clock, reset - system clock, asynchronous active-high reset
//   tx_if        - slave side of the valid/data/ready byte handshake
//   tx_serial    - serial line, idle high, registered
//   tx_busy      - frame in progress
//   tx_done      - one-cycle pulse as the stop bit ends
//   disp_data    - low 7 bits of the last accepted byte, to the hex display
module uart_tx_frame_engine
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    uart_tx_frame_engine_if.slave tx_if,
    output logic                 tx_serial,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic [DISP_BITS-1:0] disp_data
);

    uart_state_t          state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [2:0]           bit_idx_q;
    logic                 ready_q;
    logic                 bit_end;
    logic                 accept;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    assign tx_if.tx_ready = ready_q;
    assign accept         = tx_if.tx_valid && ready_q;

    // Counter is held at 0 in IDLE, so START always begins with a full bit.
    uart_baud_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_q == IDLE),
        .enable  (1'b1),
        .bit_end (bit_end)
    );

    // Payload registers: only meaningful while a frame is in flight.
    always_ff @(posedge clock) begin
        if (accept) begin
            shift_q  <= tx_if.tx_data;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^tx_if.tx_data;
`endif
        end else if (state_q == DATA && bit_end) begin
            shift_q <= shift_q >> 1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            bit_idx_q <= '0;
            tx_serial <= 1'b1;
            ready_q   <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            disp_data <= '0;
        end else begin
            tx_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q   <= START;
                        bit_idx_q <= '0;
                        tx_serial <= 1'b0;
                        ready_q   <= 1'b0;
                        tx_busy   <= 1'b1;
                        disp_data <= tx_if.tx_data[DISP_BITS-1:0];
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q   <= DATA;
                        tx_serial <= shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q   <= PARITY;
                            tx_serial <= parity_q;
`else
                            state_q   <= STOP;
                            tx_serial <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                            // shift_q shifts on this same edge, so the next bit is [1].
                            tx_serial <= shift_q[1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state_q   <= STOP;
                        tx_serial <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        tx_busy <= 1'b0;
                        tx_done <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    tx_serial <= 1'b1;
                    ready_q   <= 1'b1;
                    tx_busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Bench for uart_tx_frame_engine: one instance at CLKS_PER_BIT=4, one at 2.
// Expected per-cycle line/done/busy/display values are queued when a byte is
// driven and popped as the DUT produces each cycle of output.
module tb_uart_tx_frame_engine;

    typedef struct packed {
        logic       line;
        logic       done;
        logic       busy;
        logic [6:0] disp;
    } exp_t;

    logic clock;
    logic reset;
    logic ser_a, busy_a, done_a;
    logic ser_b, busy_b, done_b;
    logic [6:0] disp_a, disp_b;

    int total = 0;
    int bad   = 0;
    exp_t q[$];

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    uart_tx_frame_engine_if ifa ();
    uart_tx_frame_engine_if ifb ();

    uart_tx_frame_engine #(.CLKS_PER_BIT(4)) dut_a (
        .clock(clock), .reset(reset), .tx_if(ifa.slave),
        .tx_serial(ser_a), .tx_busy(busy_a), .tx_done(done_a), .disp_data(disp_a)
    );

    uart_tx_frame_engine #(.CLKS_PER_BIT(2)) dut_b (
        .clock(clock), .reset(reset), .tx_if(ifb.slave),
        .tx_serial(ser_b), .tx_busy(busy_b), .tx_done(done_b), .disp_data(disp_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_entry(input logic line, input logic done, input logic busy,
                              input logic [6:0] disp, input int n);
        exp_t e;
        e.line = line; e.done = done; e.busy = busy; e.disp = disp;
        for (int i = 0; i < n; i++) q.push_back(e);
    endtask

    task automatic push_frame(input logic [7:0] b, input int c);
        logic [7:0] v;
        v = b;
        push_entry(1'b0, 1'b0, 1'b1, v[6:0], c);
        for (int k = 0; k < 8; k++) push_entry(v[k], 1'b0, 1'b1, v[6:0], c);
`ifdef UART_TX_PARITY_EN
        push_entry(^v, 1'b0, 1'b1, v[6:0], c);
`endif
        push_entry(1'b1, 1'b0, 1'b1, v[6:0], c);
        push_entry(1'b1, 1'b1, 1'b0, v[6:0], 1);
    endtask

    task automatic check_cycles(input int sel, input int n);
        exp_t e;
        logic s, d, bz, rd;
        logic [6:0] dp;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            total++;
            assert (q.size() != 0) else begin
                bad++;
                $error("FAIL scoreboard_empty observed=0 expected=entry");
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                if (sel == 0) begin
                    s = ser_a; d = done_a; bz = busy_a; rd = ifa.tx_ready; dp = disp_a;
                end else begin
                    s = ser_b; d = done_b; bz = busy_b; rd = ifb.tx_ready; dp = disp_b;
                end
                chk("tx_serial", {7'd0, s},  {7'd0, e.line});
                chk("tx_done",   {7'd0, d},  {7'd0, e.done});
                chk("tx_busy",   {7'd0, bz}, {7'd0, e.busy});
                chk("tx_ready",  {7'd0, rd}, {7'd0, ~e.busy});
                chk("disp_data", {1'b0, dp}, {1'b0, e.disp});
            end
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] b);
        if (sel == 0) begin ifa.tx_valid = v; ifa.tx_data = b; end
        else          begin ifb.tx_valid = v; ifb.tx_data = b; end
    endtask

    task automatic drop_valid(input int sel);
        if (sel == 0) ifa.tx_valid = 1'b0;
        else          ifb.tx_valid = 1'b0;
    endtask

    task automatic send(input int sel, input logic [7:0] b, input int c);
        drive(sel, 1'b1, b);
        push_frame(b, c);
        @(posedge clock);
        #1 drop_valid(sel);
        check_cycles(sel, NBITS * c + 1);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (2) @(negedge clock);

        // Reset state
        chk("rst_serial_a", {7'd0, ser_a},        8'h01);
        chk("rst_ready_a",  {7'd0, ifa.tx_ready}, 8'h01);
        chk("rst_busy_a",   {7'd0, busy_a},       8'h00);
        chk("rst_done_a",   {7'd0, done_a},       8'h00);
        chk("rst_disp_a",   {1'b0, disp_a},       8'h00);
        chk("rst_serial_b", {7'd0, ser_b},        8'h01);
        chk("rst_ready_b",  {7'd0, ifb.tx_ready}, 8'h01);
        reset = 1'b0;
        @(negedge clock);

        // Single frame, 8'h41
        send(0, 8'h41, 4);

        // Back-to-back with tx_valid held: 8'h55 then 8'hAA
        drive(0, 1'b1, 8'h55);
        push_frame(8'h55, 4);
        push_frame(8'hAA, 4);
        @(posedge clock);
        #1 ifa.tx_data = 8'hAA;
        check_cycles(0, NBITS * 4 + 1);
        @(posedge clock);
        #1 drop_valid(0);
        check_cycles(0, NBITS * 4 + 1);

        // tx_data change and tx_valid pulse mid-frame are ignored
        drive(0, 1'b1, 8'h3C);
        push_frame(8'h3C, 4);
        push_entry(1'b1, 1'b0, 1'b0, 7'h3C, 1);
        @(posedge clock);
        #1 drop_valid(0);
        check_cycles(0, 8);
        drive(0, 1'b1, 8'hFF);
        check_cycles(0, 4);
        drop_valid(0);
        check_cycles(0, NBITS * 4 + 2 - 12);

        // Reset during data bit 3 of 8'hA5 (line low there)
        drive(0, 1'b1, 8'hA5);
        push_frame(8'hA5, 4);
        @(posedge clock);
        #1 drop_valid(0);
        check_cycles(0, 4 * 4 + 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_serial", {7'd0, ser_a},  8'h01);
        chk("abort_disp",   {1'b0, disp_a}, 8'h00);
        chk("abort_busy",   {7'd0, busy_a}, 8'h00);
        q.delete();
        @(negedge clock);
        chk("abort_done", {7'd0, done_a}, 8'h00);
        reset = 1'b0;
        push_entry(1'b1, 1'b0, 1'b0, 7'h00, 2);
        check_cycles(0, 2);
        send(0, 8'h30, 4);

`ifdef UART_TX_PARITY_EN
        // Even parity: 8'h07 -> 1, 8'h03 -> 0
        send(0, 8'h07, 4);
        send(0, 8'h03, 4);
`endif

        // CLKS_PER_BIT=2 boundary
        send(1, 8'hC3, 2);
        send(1, 8'h3A, 2);

        chk("queue_drained", 8'(q.size()), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
